load_store_unit: RTL and testbench

- Sits directly upstream of the 256 x 9-bit data memory and is the only agent that drives that memory's write-enable, address and write-data ports.
- The memory reads combinationally and writes on the clock's rising edge.
- Accepts one request at a time from the execute stage over a valid/ready handshake, performs a LOAD, STORE, PUSH or POP, and returns a registered response.
- Owns the hardware stack pointer and reports stack overflow and underflow.

---
 rtl/load_store_unit_pkg.sv | 26 ++
 rtl/load_store_unit_stack_ctrl.sv | 61 ++++++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared definitions for the load/store unit: operation
//               encodings, FSM state encodings and datapath widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 9;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_PUSH  = 2'd2;
  localparam logic [1:0] OP_POP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_stack_ctrl
// Description : Hardware stack pointer and depth counter for a downward-
//               growing stack. Flags full/empty and supplies the memory
//               addresses used by PUSH (current sp) and POP (sp + 1).
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               push, pop       - commit strobes (one cycle each)
//               sp, depth       - next free slot, entries on stack
//               full, empty     - depth at capacity / depth zero
//               push_addr       - slot written by a PUSH
//               pop_addr        - slot read by a POP
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit_stack_ctrl
  import load_store_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] STACK_BASE  = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] depth,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] pop_addr
);

  // One extra bit so the capacity computation cannot wrap.
  localparam logic [ADDR_W:0] DEPTH =
    {1'b0, STACK_BASE} - {1'b0, STACK_LIMIT} + {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] r_depth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= STACK_BASE;
      r_depth <= '0;
    end else if (push) begin
      r_sp    <= r_sp - 8'd1;
      r_depth <= r_depth + 8'd1;
    end else if (pop) begin
      r_sp    <= r_sp + 8'd1;
      r_depth <= r_depth - 8'd1;
    end
  end

  assign sp        = r_sp;
  assign depth     = r_depth;
  assign full      = ({1'b0, r_depth} == DEPTH);
  assign empty     = (r_depth == '0);
  assign push_addr = r_sp;
  assign pop_addr  = r_sp + 8'd1;   // 8-bit wrap intended

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit in front of a 256 x 9
//               data memory (combinational read, clocked write). Performs
//               LOAD, STORE, PUSH and POP and returns a registered response
//               with overflow/underflow error reporting.
// Ports       : clk, rst                   - clock, async active-high reset
//               req_valid/ready/op/addr/data - request handshake
//               rsp_valid/ready/data/err   - response handshake
//               mem_we, mem_a, mem_d       - memory write/address/data
//               mem_spo                    - memory read data
//               sp, depth                  - stack pointer and fill level
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [7:0] STACK_BASE  = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [8:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_data,
  output logic       rsp_err,
  output logic       mem_we,
  output logic [7:0] mem_a,
  output logic [8:0] mem_d,
  input  logic [8:0] mem_spo,
  output logic [7:0] sp,
  output logic [7:0] depth
);

  state_t            r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_push_addr;
  logic [ADDR_W-1:0] w_pop_addr;
  logic              w_push;
  logic              w_pop;

  // Stack commits happen on the edge that leaves ACCESS.
  assign w_push = (r_state == ST_ACCESS) && (r_op == OP_PUSH) && !r_err;
  assign w_pop  = (r_state == ST_ACCESS) && (r_op == OP_POP)  && !r_err;

  load_store_unit_stack_ctrl #(
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_stack_ctrl (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .sp        (sp),
    .depth     (depth),
    .full      (w_full),
    .empty     (w_empty),
    .push_addr (w_push_addr),
    .pop_addr  (w_pop_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_LOAD;
      r_addr     <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_data  <= req_data;
            // Decide overflow/underflow now so ACCESS never touches memory.
            r_err   <= ((req_op == OP_PUSH) && w_full) ||
                       ((req_op == OP_POP)  && w_empty);
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_RESP;
          if (r_err) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_rsp_err  <= 1'b0;
            if ((r_op == OP_LOAD) || (r_op == OP_POP)) begin
              r_rsp_data <= mem_spo;
            end else begin
              r_rsp_data <= '0;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_err <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is decoded from state so an async reset drops mem_we at once.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_d  = '0;
    if (r_state == ST_ACCESS) begin
      mem_d = r_data;
      case (r_op)
        OP_LOAD: mem_a = r_addr;
        OP_STORE: begin
          mem_a  = r_addr;
          mem_we = 1'b1;
        end
        OP_PUSH: begin
          if (!r_err) begin
            mem_a  = w_push_addr;
            mem_we = 1'b1;
          end
        end
        OP_POP: begin
          if (!r_err) begin
            mem_a = w_pop_addr;
          end
        end
        default: mem_a = '0;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               reset-clearable behavioural memory, a reference stack model
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  typedef struct packed {
    logic       err;
    logic [8:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [8:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_data;
  logic       rsp_err;
  logic       mem_we;
  logic [7:0] mem_a;
  logic [8:0] mem_d;
  logic [8:0] mem_spo;
  logic [7:0] sp;
  logic [7:0] depth;

  logic [8:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  exp_t       exp_q[$];
  logic [8:0] m_mem [256];
  logic [7:0] m_sp;
  logic [8:0] m_depth;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_spo   (mem_spo),
    .sp        (sp),
    .depth     (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, clocked write, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_a] <= mem_d;
    end
  end
  assign mem_spo = mem[mem_a];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_sp    = 8'hFF;
    m_depth = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pop the next expected response; an empty scoreboard is itself a failure.
  task automatic sb_pop(output exp_t e);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=nonzero");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [8:0] d);
    exp_t       e;
    exp_t       got;
    logic       we_exp;
    logic [7:0] a_exp;
    logic       err;
    err    = ((op == 2'd2) && (m_depth == 9'd128)) || ((op == 2'd3) && (m_depth == 9'd0));
    we_exp = 1'b0;
    a_exp  = a;
    e.err  = err;
    e.data = '0;
    case (op)
      2'd0: e.data = m_mem[a];
      2'd1: begin we_exp = 1'b1; m_mem[a] = d; end
      2'd2: if (!err) begin
        we_exp = 1'b1; a_exp = m_sp; m_mem[m_sp] = d;
        m_sp = m_sp - 8'd1; m_depth = m_depth + 9'd1;
      end
      default: if (!err) begin
        a_exp = m_sp + 8'd1; e.data = m_mem[a_exp];
        m_sp = m_sp + 8'd1; m_depth = m_depth - 9'd1;
      end
    endcase
    @(negedge clk);
    chk("req_ready_idle", {8'd0, req_ready}, 9'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsp_valid_accept1", {8'd0, rsp_valid}, 9'd0);
    chk("mem_we_access", {8'd0, mem_we}, {8'd0, we_exp});
    if (!err) chk("mem_a_access", {1'b0, mem_a}, {1'b0, a_exp});
    if (we_exp) chk("mem_d_access", mem_d, d);
    @(posedge clk); #1;
    chk("rsp_valid_accept2", {8'd0, rsp_valid}, 9'd1);
    chk("req_ready_resp", {8'd0, req_ready}, 9'd0);
    chk("mem_we_resp", {8'd0, mem_we}, 9'd0);
    sb_pop(got);
    chk("rsp_data", rsp_data, got.data);
    chk("rsp_err", {8'd0, rsp_err}, {8'd0, got.err});
    @(posedge clk); #1;
    chk("rsp_valid_done", {8'd0, rsp_valid}, 9'd0);
    chk("sp", {1'b0, sp}, {1'b0, m_sp});
    chk("depth", {1'b0, depth}, m_depth);
  endtask

  initial begin
    exp_t e;
    exp_t got;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b1;
    model_clear();
    #22;
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_req_ready", {8'd0, req_ready}, 9'd1);
    chk("rst_rsp_valid", {8'd0, rsp_valid}, 9'd0);
    chk("rst_rsp_data", rsp_data, 9'd0);
    chk("rst_rsp_err", {8'd0, rsp_err}, 9'd0);
    chk("rst_sp", {1'b0, sp}, 9'h0FF);
    chk("rst_depth", {1'b0, depth}, 9'd0);
    chk("rst_mem_we", {8'd0, mem_we}, 9'd0);
    chk("rst_mem_a", {1'b0, mem_a}, 9'd0);
    chk("rst_mem_d", mem_d, 9'd0);

    // STORE then LOAD
    send(2'd1, 8'h10, 9'h1A5);
    send(2'd0, 8'h10, 9'h000);
    chk("mem10", mem[8'h10], 9'h1A5);

    // PUSH, PUSH, POP, POP
    send(2'd2, 8'h00, 9'h011);
    send(2'd2, 8'h00, 9'h022);
    send(2'd3, 8'h00, 9'h000);
    send(2'd3, 8'h00, 9'h000);

    // Underflow after reset
    do_reset();
    send(2'd3, 8'h00, 9'h000);

    // Fill the stack, then overflow
    for (int i = 0; i < 128; i++) send(2'd2, 8'h00, 9'((i * 3 + 1) & 9'h1FF));
    chk("full_sp", {1'b0, sp}, 9'h07F);
    chk("full_depth", {1'b0, depth}, 9'd128);
    send(2'd2, 8'h00, 9'h1FF);
    chk("mem7f_untouched", mem[8'h7F], 9'h000);

    // Backpressure on a LOAD from inside the stack region
    e.err = 1'b0; e.data = m_mem[8'h90];
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 8'h90; req_data = '0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    sb_pop(got);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 8'h20; req_data = 9'h0AB;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", {8'd0, rsp_valid}, 9'd1);
      chk("bp_rsp_data", rsp_data, got.data);
      chk("bp_req_ready", {8'd0, req_ready}, 9'd0);
      chk("bp_mem_we", {8'd0, mem_we}, 9'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_valid", {8'd0, rsp_valid}, 9'd0);
    chk("bp_handshake_ready", {8'd0, req_ready}, 9'd1);
    chk("bp_pending_not_taken", {8'd0, mem_we}, 9'd0);
    m_mem[8'h20] = 9'h0AB;
    e.err = 1'b0; e.data = '0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_store_we", {8'd0, mem_we}, 9'd1);
    chk("bp_store_a", {1'b0, mem_a}, 9'h020);
    @(posedge clk); #1;
    sb_pop(got);
    chk("bp_store_rsp_data", rsp_data, got.data);
    chk("bp_store_rsp_err", {8'd0, rsp_err}, {8'd0, got.err});
    @(posedge clk); #1;
    chk("bp_mem20", mem[8'h20], 9'h0AB);

    // Reset during the ACCESS cycle of a PUSH
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_addr = '0; req_data = 9'h155;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstmid_we_before", {8'd0, mem_we}, 9'd1);
    chk("rstmid_a_before", {1'b0, mem_a}, 9'h0FF);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_we", {8'd0, mem_we}, 9'd0);
    chk("rstmid_ready", {8'd0, req_ready}, 9'd1);
    chk("rstmid_rsp_valid", {8'd0, rsp_valid}, 9'd0);
    chk("rstmid_sp", {1'b0, sp}, 9'h0FF);
    chk("rstmid_depth", {1'b0, depth}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("rstmid_idle", {8'd0, req_ready}, 9'd1);
    chk("rstmid_memff", mem[8'hFF], 9'h000);
    chk("rstmid_sp_after", {1'b0, sp}, 9'h0FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
